// File: rtl/mem_access_unit.sv
// Memory-stage access unit: drives a req/ack memory bus for loads and stores,
// stalls the M stage while an access is outstanding, and registers the
// M->W pipeline outputs including byte-lane-extracted load data.
module mem_access_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic                  StSrcM,
  input  logic                  LdSrcM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [4:0]            RdM,
  input  logic [DATA_WIDTH-1:0] PC_PlusM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW,
  output logic [DATA_WIDTH-1:0] ALUResultW,
  output logic [DATA_WIDTH-1:0] ReadDataW,
  output logic [4:0]            RdW,
  output logic [DATA_WIDTH-1:0] PC_PlusW,
  output logic                  StallM
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  reg_write_w_q, reg_write_w_d;
  logic [1:0]            result_src_w_q, result_src_w_d;
  logic [DATA_WIDTH-1:0] alu_result_w_q, alu_result_w_d;
  logic [DATA_WIDTH-1:0] read_data_w_q, read_data_w_d;
  logic [4:0]            rd_w_q, rd_w_d;
  logic [DATA_WIDTH-1:0] pc_plus_w_q, pc_plus_w_d;

  logic                  is_load;
  logic                  access;
  logic                  byte_acc;
  logic                  complete;
  logic [DATA_WIDTH-1:0] load_data;

  // Select byte lane 'lane' of a bus word and zero-extend it.
  function automatic logic [DATA_WIDTH-1:0] extract_byte(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            lane
  );
    logic [DATA_WIDTH-1:0] shifted;
    shifted = word >> {lane, 3'b000};
    return {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
  endfunction

  // Bus request, lane enables and store data derived from the M-stage inputs.
  always_comb begin
    is_load   = (ResultSrcM == 2'b01);
    access    = MemWriteM | is_load;
    byte_acc  = MemWriteM ? StSrcM : LdSrcM;
    mem_req   = (state_q == BUSY) | access;
    StallM    = mem_req & ~mem_ack;
    mem_we    = mem_req & MemWriteM;
    mem_addr  = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
    mem_be    = byte_acc ? (4'b0001 << ALUResultM[1:0]) : 4'b1111;
    mem_wdata = StSrcM ? {(DATA_WIDTH/8){WriteDataM[7:0]}} : WriteDataM;
    load_data = LdSrcM ? extract_byte(mem_rdata, ALUResultM[1:0]) : mem_rdata;
    // A non-access retires immediately; an access retires on the acked cycle.
    complete  = ((state_q == IDLE) & ~access) | (mem_req & mem_ack);
  end

  // Next-state and writeback register update: load on completion, bubble on stall.
  always_comb begin
    state_d        = state_q;
    reg_write_w_d  = reg_write_w_q;
    result_src_w_d = result_src_w_q;
    alu_result_w_d = alu_result_w_q;
    read_data_w_d  = read_data_w_q;
    rd_w_d         = rd_w_q;
    pc_plus_w_d    = pc_plus_w_q;
    if (complete) begin
      state_d        = IDLE;
      reg_write_w_d  = RegWriteM;
      result_src_w_d = ResultSrcM;
      alu_result_w_d = ALUResultM;
      read_data_w_d  = is_load ? load_data : '0;
      rd_w_d         = RdM;
      pc_plus_w_d    = PC_PlusM;
    end else begin
      state_d        = BUSY;
      reg_write_w_d  = 1'b0;
    end
  end

  // State and writeback registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= '0;
      alu_result_w_q <= '0;
      read_data_w_q  <= '0;
      rd_w_q         <= '0;
      pc_plus_w_q    <= '0;
    end else begin
      state_q        <= state_d;
      reg_write_w_q  <= reg_write_w_d;
      result_src_w_q <= result_src_w_d;
      alu_result_w_q <= alu_result_w_d;
      read_data_w_q  <= read_data_w_d;
      rd_w_q         <= rd_w_d;
      pc_plus_w_q    <= pc_plus_w_d;
    end
  end

  assign RegWriteW  = reg_write_w_q;
  assign ResultSrcW = result_src_w_q;
  assign ALUResultW = alu_result_w_q;
  assign ReadDataW  = read_data_w_q;
  assign RdW        = rd_w_q;
  assign PC_PlusW   = pc_plus_w_q;

endmodule
